// File: rtl/counter_sched.sv
// Command-driven interval timer: sequences an up-counter against a compare value,
// raising a sticky irq and a one-cycle match pulse in one-shot or periodic mode.
module counter_sched #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_periodic,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             irq,
  output logic             match
);

  localparam logic [1:0] OpStart = 2'b00;
  localparam logic [1:0] OpStop  = 2'b01;
  localparam logic [1:0] OpLoad  = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             periodic_q, periodic_d;
  logic             irq_q, irq_d;
  logic             match_q, match_d;
  logic             cmd_accept;

  // START and LOAD_CMP stall while running; STOP and CLEAR always go through.
  always_comb begin
    cmd_ready = (state_q != StRun) || (cmd_op == OpStop) || (cmd_op == OpClear);
  end

  assign cmd_accept = cmd_valid && cmd_ready;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    cmp_d      = cmp_q;
    periodic_d = periodic_q;
    irq_d      = irq_q && !irq_clr;
    match_d    = 1'b0;

    if (cmd_accept) begin
      unique case (cmd_op)
        OpStart: begin
          count_d    = '0;
          periodic_d = cmd_periodic;
          state_d    = StRun;
        end
        OpStop: begin
          state_d = StIdle;
        end
        OpLoad: begin
          cmp_d = cmd_data;
        end
        OpClear: begin
          count_d = '0;
          irq_d   = 1'b0;
          state_d = StIdle;
        end
        default: ;
      endcase
    end else if (state_q == StRun) begin
      if (count_q == cmp_q) begin
        // Match set beats a coincident irq_clr.
        match_d = 1'b1;
        irq_d   = 1'b1;
        if (periodic_q) begin
          count_d = '0;
        end else begin
          state_d = StDone;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      cmp_q      <= '0;
      periodic_q <= 1'b0;
      irq_q      <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      periodic_q <= periodic_d;
      irq_q      <= irq_d;
      match_q    <= match_d;
    end
  end

  assign count_out = count_q;
  assign busy      = (state_q == StRun);
  assign irq       = irq_q;
  assign match     = match_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: stimulus pushes hand-computed post-edge state into a
// scoreboard queue; a monitor pops and compares one entry after every rising edge.
module tb_counter_sched;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         cmd_periodic;
  logic         irq_clr;
  logic [W-1:0] count_out;
  logic         busy;
  logic         irq;
  logic         match;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         busy;
    logic         irq;
    logic         match;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  counter_sched #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_periodic (cmd_periodic),
    .irq_clr      (irq_clr),
    .count_out    (count_out),
    .busy         (busy),
    .irq          (irq),
    .match        (match)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge once stimulus has queued it.
  always @(posedge clk) begin
    exp_t  e;
    string t;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".count"}, int'(count_out), int'(e.cnt));
      chk({t, ".busy"},  int'(busy),      int'(e.busy));
      chk({t, ".irq"},   int'(irq),       int'(e.irq));
      chk({t, ".match"}, int'(match),     int'(e.match));
    end
  end

  // Called at a falling edge: drive inputs, optionally check cmd_ready, queue the
  // expected post-edge state and advance to the next falling edge.
  task automatic cyc(input logic rst_n, input logic v, input logic [1:0] op,
                     input logic [W-1:0] data, input logic per, input logic clr,
                     input int rdy, input int e_cnt, input logic e_busy,
                     input logic e_irq, input logic e_match, input string tag);
    exp_t e;
    reset        = rst_n;
    cmd_valid    = v;
    cmd_op       = op;
    cmd_data     = data;
    cmd_periodic = per;
    irq_clr      = clr;
    #1;
    if (rdy >= 0) chk({tag, ".ready"}, int'(cmd_ready), rdy);
    e.cnt   = W'(e_cnt);
    e.busy  = e_busy;
    e.irq   = e_irq;
    e.match = e_match;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int e_cnt, input logic e_busy, input logic e_irq,
                      input logic e_match, input string tag);
    cyc(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b0, -1, e_cnt, e_busy, e_irq, e_match, tag);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
    cmd_periodic = 1'b0; irq_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc(1'b0, 1'b0, 2'b00, '0, 1'b0, 1'b0, -1, 0, 0, 0, 0, "reset");

    // One-shot, cmp=5
    cyc(1'b1, 1'b1, 2'b10, 8'd5, 1'b0, 1'b0, 1, 0, 0, 0, 0, "os_load5");
    cyc(1'b1, 1'b1, 2'b00, '0, 1'b0, 1'b0, 1, 0, 1, 0, 0, "os_start");
    for (int k = 1; k <= 5; k++) idle(k, 1, 0, 0, "os_run");
    idle(5, 0, 1, 1, "os_match");
    cyc(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b0, 1, 5, 0, 1, 0, "os_done");
    cyc(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b1, -1, 5, 0, 0, 0, "irqclr_done");

    // Periodic, cmp=3, restart from DONE; irq_clr in the third match cycle
    cyc(1'b1, 1'b1, 2'b10, 8'd3, 1'b0, 1'b0, 1, 5, 0, 0, 0, "per_load3");
    cyc(1'b1, 1'b1, 2'b00, '0, 1'b1, 1'b0, 1, 0, 1, 0, 0, "per_start");
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 3; k++) idle(k, 1, (p > 0), 0, "per_run");
      cyc(1'b1, 1'b0, 2'b00, '0, 1'b0, (p == 2), -1, 0, 1, 1, 1, "per_match");
    end
    cyc(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b1, -1, 1, 1, 0, 0, "irqclr_nomatch");

    // LOAD_CMP stalls in RUN until STOP is accepted
    cyc(1'b1, 1'b1, 2'b10, 8'd9, 1'b0, 1'b0, 0, 2, 1, 0, 0, "load_stall");
    cyc(1'b1, 1'b1, 2'b01, '0, 1'b0, 1'b0, 1, 2, 0, 0, 0, "stop");
    cyc(1'b1, 1'b1, 2'b10, 8'd9, 1'b0, 1'b0, 1, 2, 0, 0, 0, "load9");
    cyc(1'b1, 1'b1, 2'b00, '0, 1'b0, 1'b0, 1, 0, 1, 0, 0, "os9_start");
    for (int k = 1; k <= 9; k++) idle(k, 1, 0, 0, "os9_run");
    idle(9, 0, 1, 1, "os9_match");

    // cmp=0 periodic, then CLEAR with irq_clr in a match cycle
    cyc(1'b1, 1'b1, 2'b10, 8'd0, 1'b0, 1'b1, 1, 9, 0, 0, 0, "load0_clr");
    cyc(1'b1, 1'b1, 2'b00, '0, 1'b1, 1'b0, 1, 0, 1, 0, 0, "c0_start");
    for (int k = 0; k < 3; k++) idle(0, 1, 1, 1, "c0_match");
    cyc(1'b1, 1'b1, 2'b11, '0, 1'b0, 1'b1, 1, 0, 0, 0, 0, "c0_clear");
    idle(0, 0, 0, 0, "c0_idle");

    // All-ones compare: 256-cycle period
    cyc(1'b1, 1'b1, 2'b10, 8'hff, 1'b0, 1'b0, 1, 0, 0, 0, 0, "max_load");
    cyc(1'b1, 1'b1, 2'b00, '0, 1'b1, 1'b0, 1, 0, 1, 0, 0, "max_start");
    for (int k = 1; k <= 255; k++) idle(k, 1, 0, 0, "max_run");
    idle(0, 1, 1, 1, "max_match");
    for (int k = 1; k <= 7; k++) idle(k, 1, 1, 0, "max_wrap");

    // Reset mid-RUN at count 7 overrides a simultaneous START
    cyc(1'b0, 1'b1, 2'b00, '0, 1'b1, 1'b0, -1, 0, 0, 0, 0, "rst_run");
    idle(0, 0, 0, 0, "rst_after");

    // STOP in the match cycle: no match, count holds
    cyc(1'b1, 1'b1, 2'b10, 8'd2, 1'b0, 1'b0, 1, 0, 0, 0, 0, "sm_load2");
    cyc(1'b1, 1'b1, 2'b00, '0, 1'b1, 1'b0, 1, 0, 1, 0, 0, "sm_start");
    idle(1, 1, 0, 0, "sm_run");
    idle(2, 1, 0, 0, "sm_run");
    cyc(1'b1, 1'b1, 2'b01, '0, 1'b0, 1'b0, 1, 2, 0, 0, 0, "sm_stop");
    idle(2, 0, 0, 0, "sm_idle");

    @(posedge clk);
    #2;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
# counter_sched

Command-driven controller that sequences a free-running up-counter as a programmable interval timer. It accepts start/stop/load/clear commands over a valid/ready interface, runs the counter up to a compare value, and raises a sticky interrupt plus a one-cycle match pulse at each match. Operation is one-shot or periodic. The block sits between the core's control logic and the counting datapath, and is the only writer of the count.

## Interface
- `WIDTH`, default 32: count and compare width in bits.
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op`  in  2: command opcode; 00 START, 01 STOP, 10 LOAD_CMP, 11 CLEAR.
- `cmd_data`  in  WIDTH: compare value for LOAD_CMP; ignored otherwise.
- `cmd_periodic`  in  1: mode for START; 1 periodic, 0 one-shot. Ignored otherwise.
- `irq_clr`  in  1: clears `irq`.
- `count_out`  out  WIDTH: current registered count.
- `busy`  out  1: high in RUN.
- `irq`  out  1: sticky match interrupt.
- `match`  out  1: one-cycle pulse per match.

## Operation
- States:
  - IDLE: stopped, count held.
  - RUN: counting.
  - DONE: one-shot finished, count held at `cmp`.
- Internal registers:
  - `cmp` (WIDTH): compare value.
  - `periodic` (1): run mode.
  - `count` (WIDTH): drives `count_out`.
- `cmd_ready` is combinational:
  - 1 in IDLE and DONE.
  - In RUN, 1 only when `cmd_op` is STOP or CLEAR.
  - START and LOAD_CMP stall in RUN until the block leaves RUN.
- START (accepted):
  - `count` <= 0, `periodic` <= `cmd_periodic`, state <= RUN.
  - Valid from IDLE or DONE, and restarts from DONE.
- STOP: state <= IDLE; `count`, `irq` and `cmp` hold.
- LOAD_CMP: `cmp` <= `cmd_data`; state and `count` unchanged.
- CLEAR: `count` <= 0, `irq` <= 0, state <= IDLE; `cmp` and `periodic` hold.
- RUN, no accepted command, `count == cmp`:
  - `match` <= 1, `irq` <= 1.
  - Periodic: `count` <= 0, stay in RUN.
  - One-shot: `count` holds, state <= DONE.
- RUN, no accepted command, `count != cmp`: `count` <= `count + 1`, `match` <= 0.
- Outside RUN, `match` <= 0.
- Arithmetic and width:
  - Unsigned, WIDTH bits.
  - `count` never exceeds `cmp` while running, so no natural wrap.
  - `cmp` = all-ones gives a 2^WIDTH-cycle period.
- `busy` = (state == RUN).

## Timing
- Reset (`reset` low at an edge): state IDLE, `count`=0, `cmp`=0, `periodic`=0, `irq`=0, `match`=0, `busy`=0. `cmd_ready`=1 follows from IDLE.
- Reset overrides any command or `irq_clr` in the same cycle, including mid-RUN.
- Latency:
  - After START accepted at edge E0, `count_out`=k after edge E0+k.
  - `match` and `irq` rise after edge E0+`cmp`+1.
  - Periodic: `match` every `cmp`+1 cycles.
- `cmp`=0 periodic: `count` stays 0 and `match` is high every cycle from E0+1.
- Simultaneous events:
  - Match-set of `irq` in the same cycle as `irq_clr`: set wins, `irq`=1.
  - Accepted CLEAR with `irq_clr`, or with a match: CLEAR wins, `irq`=0, `match`=0.
  - Accepted STOP in the match cycle: STOP wins, no `match`, `irq` unchanged, `count` holds.
- `irq_clr` alone: `irq` <= 0 next edge.
- Command inputs are ignored when `cmd_valid` is low.

## Test plan
- Reset then LOAD_CMP 5 and START one-shot at E0 → `count_out` 0..5 over E0..E0+5. `match`=1 and `irq`=1 after E0+6. DONE with `count_out`=5, `busy`=0.
- `cmp`=3 periodic START → `match` pulses after E0+4, E0+8, E0+12; `count_out` sequence 0,1,2,3,0,1…; `busy` stays 1.
- In RUN, present LOAD_CMP 9 → `cmd_ready`=0 until STOP is accepted. Then LOAD_CMP is accepted next cycle; `cmp`=9, `count_out` held.
- `irq`=1 with `irq_clr` asserted in a periodic match cycle → `irq` stays 1. `irq_clr` on a non-match cycle → `irq`=0 next edge.
- `cmp`=0 periodic START → `match`=1 every cycle from E0+1 and `count_out`=0 throughout. CLEAR → `irq`=0, `match`=0, IDLE next edge.
- `reset` low while in RUN at `count_out`=7 → next edge all outputs at reset values. A START presented in the same cycle is not accepted.
